// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encodings, instruction field positions, NOP word.
// Also holds the PC alignment helper used by the fetch stage.
package mips_pkg;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_HOLD  = 2'd2;
    localparam logic [1:0] FS_DRAIN = 2'd3;

    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instruction} holding slot for a word that returned while IF/ID was stalled.
module fetch_skid_buffer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next-state for the slot: clear beats load, load beats drain.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC, imem req/ready fetch FSM, IF/ID pipeline register and field slicing.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        stall,
    input  logic        flush,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        ifIdValid,
    output logic [31:0] ifIdPc,
    output logic [31:0] ifIdPcPlus4,
    output logic [31:0] ifIdInstruction,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] jumpIndex
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        imem_req_s, transfer_s, load_s;
    logic [31:0] redirect_s, load_pc_s, load_instr_s;
    logic        skid_load_s, skid_drain_s, skid_clear_s, skid_valid_s;
    logic [31:0] skid_pc_s, skid_instr_s;

    assign imem_req_s = (state_q == FS_FETCH) || (state_q == FS_DRAIN);
    assign transfer_s = imem_req_s & imemReady;
    assign redirect_s = word_align(branchTarget);

    // Fetch FSM and PC update; a redirect with a request still in flight parks in DRAIN.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        skid_clear_s = 1'b0;
        load_s       = 1'b0;
        load_pc_s    = pc_q;
        load_instr_s = imemData;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
                if (branchTaken) pc_d = redirect_s;
                else             pc_d = pc_q;
            end
            FS_FETCH: begin
                if (branchTaken) begin
                    if (transfer_s) begin
                        pc_d = redirect_s;
                    end else begin
                        target_d = redirect_s;
                        state_d  = FS_DRAIN;
                    end
                end else if (transfer_s) begin
                    pc_d = pc_q + PC_STEP;
                    if (stall) begin
                        skid_load_s = 1'b1;
                        state_d     = FS_HOLD;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = FS_FETCH;
                end
            end
            FS_HOLD: begin
                if (branchTaken) begin
                    pc_d         = redirect_s;
                    skid_clear_s = 1'b1;
                    state_d      = FS_FETCH;
                end else if (!stall) begin
                    skid_drain_s = 1'b1;
                    load_s       = skid_valid_s;
                    load_pc_s    = skid_pc_s;
                    load_instr_s = skid_instr_s;
                    state_d      = FS_FETCH;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            FS_DRAIN: begin
                if (transfer_s) begin
                    pc_d    = branchTaken ? redirect_s : target_q;
                    state_d = FS_FETCH;
                end else if (branchTaken) begin
                    target_d = redirect_s;
                end else begin
                    state_d = FS_DRAIN;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // IF/ID register next state: flush beats stall beats load; otherwise a bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_WORD;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (load_s) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = load_pc_s;
            ifid_pc4_d   = load_pc_s + PC_STEP;
            ifid_instr_d = load_instr_s;
        end else begin
            ifid_valid_d = 1'b0;
        end
    end

    // Fetch state, PC and IF/ID registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            target_q     <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_WORD;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk      (clock),
        .rst_n    (resetN),
        .load     (skid_load_s),
        .drain    (skid_drain_s),
        .clear    (skid_clear_s),
        .pc_in    (pc_q),
        .instr_in (imemData),
        .valid    (skid_valid_s),
        .pc       (skid_pc_s),
        .instr    (skid_instr_s)
    );

    assign imemReq         = imem_req_s;
    assign imemAddr        = pc_q;
    assign ifIdValid       = ifid_valid_q;
    assign ifIdPc          = ifid_pc_q;
    assign ifIdPcPlus4     = ifid_pc4_q;
    assign ifIdInstruction = ifid_instr_q;
    assign opcode          = ifid_instr_q[OPCODE_LSB +: 6];
    assign rs              = ifid_instr_q[RS_LSB +: 5];
    assign rt              = ifid_instr_q[RT_LSB +: 5];
    assign rd              = ifid_instr_q[RD_LSB +: 5];
    assign shamt           = ifid_instr_q[SHAMT_LSB +: 5];
    assign funct           = ifid_instr_q[FUNCT_LSB +: 6];
    assign immediate       = ifid_instr_q[15:0];
    assign jumpIndex       = ifid_instr_q[25:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed table-driven bench for the IF stage, plus a second instance with a wrapping reset PC.
module tb_instruction_fetch_stage;

    localparam logic [31:0] TAG = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        resetN, stall, flush, branchTaken, imemReady;
    logic [31:0] branchTarget, imemData;
    logic        use_ovr;
    logic [31:0] ovr_word;

    logic        imemReq, ifIdValid;
    logic [31:0] imemAddr, ifIdPc, ifIdPcPlus4, ifIdInstruction;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] jumpIndex;

    logic        b_req, b_valid;
    logic [31:0] b_addr, b_pc, b_pc4, b_instr;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
    logic [15:0] b_imm;
    logic [25:0] b_jidx;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    // Memory model: each word carries its own address plus a tag.
    always_comb imemData = use_ovr ? ovr_word : (imemAddr + TAG);

    instruction_fetch_stage dut (
        .clock(clock), .resetN(resetN), .stall(stall), .flush(flush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
        .ifIdValid(ifIdValid), .ifIdPc(ifIdPc), .ifIdPcPlus4(ifIdPcPlus4),
        .ifIdInstruction(ifIdInstruction), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .immediate(immediate), .jumpIndex(jumpIndex)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock(clock), .resetN(resetN), .stall(stall), .flush(flush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(b_req), .imemAddr(b_addr), .imemReady(imemReady), .imemData(imemData),
        .ifIdValid(b_valid), .ifIdPc(b_pc), .ifIdPcPlus4(b_pc4),
        .ifIdInstruction(b_instr), .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .shamt(b_shamt), .funct(b_funct), .immediate(b_imm), .jumpIndex(b_jidx)
    );

    typedef struct {
        logic        stall, flush, br;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                                input logic r, input logic q, input logic [31:0] a,
                                input logic v, input logic [31:0] p, input logic [31:0] w);
        vec_t x;
        x.stall = s; x.flush = f; x.br = b; x.tgt = t; x.rdy = r;
        x.e_req = q; x.e_addr = a; x.e_valid = v; x.e_pc = p; x.e_instr = w;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN = 1'b0; stall = 1'b0; flush = 1'b0; branchTaken = 1'b0;
        branchTarget = 32'd0; imemReady = 1'b1; use_ovr = 1'b0; ovr_word = 32'd0;

        vecs[0]  = mk(0,0,0,32'h0,  1, 1,32'h0,   0,32'h0,   32'h0);
        vecs[1]  = mk(0,0,0,32'h0,  1, 1,32'h4,   1,32'h0,   TAG + 32'h0);
        vecs[2]  = mk(0,0,0,32'h0,  1, 1,32'h8,   1,32'h4,   TAG + 32'h4);
        vecs[3]  = mk(0,0,0,32'h0,  1, 1,32'hC,   1,32'h8,   TAG + 32'h8);
        vecs[4]  = mk(0,0,0,32'h0,  1, 1,32'h10,  1,32'hC,   TAG + 32'hC);
        vecs[5]  = mk(1,0,0,32'h0,  1, 0,32'h14,  1,32'hC,   TAG + 32'hC);
        vecs[6]  = mk(1,0,0,32'h0,  1, 0,32'h14,  1,32'hC,   TAG + 32'hC);
        vecs[7]  = mk(1,0,0,32'h0,  1, 0,32'h14,  1,32'hC,   TAG + 32'hC);
        vecs[8]  = mk(0,0,0,32'h0,  1, 1,32'h14,  1,32'h10,  TAG + 32'h10);
        vecs[9]  = mk(0,0,0,32'h0,  1, 1,32'h18,  1,32'h14,  TAG + 32'h14);
        vecs[10] = mk(0,0,0,32'h0,  0, 1,32'h18,  0,32'h14,  TAG + 32'h14);
        vecs[11] = mk(0,0,1,32'h103,0, 1,32'h18,  0,32'h14,  TAG + 32'h14);
        vecs[12] = mk(0,0,0,32'h0,  0, 1,32'h18,  0,32'h14,  TAG + 32'h14);
        vecs[13] = mk(0,0,0,32'h0,  0, 1,32'h18,  0,32'h14,  TAG + 32'h14);
        vecs[14] = mk(0,0,0,32'h0,  1, 1,32'h100, 0,32'h14,  TAG + 32'h14);
        vecs[15] = mk(0,0,0,32'h0,  1, 1,32'h104, 1,32'h100, TAG + 32'h100);
        vecs[16] = mk(1,1,1,32'h40, 1, 1,32'h40,  0,32'h100, 32'h0);
        vecs[17] = mk(0,0,0,32'h0,  1, 1,32'h44,  1,32'h40,  TAG + 32'h40);
        vecs[18] = mk(0,0,1,32'h200,0, 1,32'h44,  0,32'h40,  TAG + 32'h40);
        vecs[19] = mk(0,0,1,32'h300,0, 1,32'h44,  0,32'h40,  TAG + 32'h40);
        vecs[20] = mk(0,0,0,32'h0,  1, 1,32'h300, 0,32'h40,  TAG + 32'h40);
        vecs[21] = mk(0,0,0,32'h0,  1, 1,32'h304, 1,32'h300, TAG + 32'h300);
        vecs[22] = mk(1,0,0,32'h0,  1, 0,32'h308, 1,32'h300, TAG + 32'h300);
        vecs[23] = mk(1,0,1,32'h80, 1, 1,32'h80,  1,32'h300, TAG + 32'h300);
        vecs[24] = mk(0,0,0,32'h0,  1, 1,32'h84,  1,32'h80,  TAG + 32'h80);
        vecs[25] = mk(0,0,1,32'h10, 1, 1,32'h10,  0,32'h80,  TAG + 32'h80);
        vecs[26] = mk(0,0,0,32'h0,  1, 1,32'h14,  1,32'h10,  TAG + 32'h10);

        step();
        step();
        chk("rst_req",   {31'd0, imemReq}, 32'd0);
        chk("rst_addr",  imemAddr, 32'd0);
        chk("rst_valid", {31'd0, ifIdValid}, 32'd0);
        chk("rst_pc",    ifIdPc, 32'd0);
        chk("rst_pc4",   ifIdPcPlus4, 32'd0);
        chk("rst_instr", ifIdInstruction, 32'd0);
        chk("rst_wrap_addr", b_addr, 32'hFFFF_FFFC);
        resetN = 1'b1;

        for (int i = 0; i < 27; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; branchTaken = vecs[i].br;
            branchTarget = vecs[i].tgt; imemReady = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_req", i),   {31'd0, imemReq}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imemAddr, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, ifIdValid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i),    ifIdPc, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), ifIdInstruction, vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i),   ifIdPcPlus4, (i == 0) ? 32'd0 : vecs[i].e_pc + 32'd4);
            if (i == 0) begin
                chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap_addr1", b_addr, 32'h0);
                chk("wrap_pc",    b_pc, 32'hFFFF_FFFC);
                chk("wrap_pc4",   b_pc4, 32'h0);
            end
        end
        stall = 1'b0; flush = 1'b0; branchTaken = 1'b0; imemReady = 1'b1;

        // Field slicing: addi $t0,$zero,-1 then add $t0,$t1,$t2.
        use_ovr = 1'b1; ovr_word = 32'h2008_FFFF;
        step();
        chk("addi_opcode", {26'd0, opcode}, 32'd8);
        chk("addi_rs",     {27'd0, rs}, 32'd0);
        chk("addi_rt",     {27'd0, rt}, 32'd8);
        chk("addi_imm",    {16'd0, immediate}, 32'h0000_FFFF);
        chk("addi_jidx",   {6'd0, jumpIndex}, 32'h0008_FFFF);
        ovr_word = 32'h012A_4020;
        step();
        chk("add_opcode", {26'd0, opcode}, 32'd0);
        chk("add_rs",     {27'd0, rs}, 32'd9);
        chk("add_rt",     {27'd0, rt}, 32'd10);
        chk("add_rd",     {27'd0, rd}, 32'd8);
        chk("add_shamt",  {27'd0, shamt}, 32'd0);
        chk("add_funct",  {26'd0, funct}, 32'h20);
        use_ovr = 1'b0;

        // Async reset while a request is outstanding.
        imemReady = 1'b0;
        step();
        chk("pend_req", {31'd0, imemReq}, 32'd1);
        #3;
        resetN = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imemReq}, 32'd0);
        chk("arst_addr",  imemAddr, 32'd0);
        chk("arst_valid", {31'd0, ifIdValid}, 32'd0);
        chk("arst_pc",    ifIdPc, 32'd0);
        chk("arst_pc4",   ifIdPcPlus4, 32'd0);
        chk("arst_instr", ifIdInstruction, 32'd0);
        chk("arst_wrap_addr", b_addr, 32'hFFFF_FFFC);
        step();
        resetN = 1'b1;
        imemReady = 1'b1;
        step();
        step();
        chk("post_rst_pc", ifIdPc, 32'd0);
        chk("post_rst_valid", {31'd0, ifIdValid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
